// File: rtl/axi_dc_token_pkg.sv
// Shared helpers for the token-ring dual-clock channel: one-hot rotate and reset value.
// Pure constants/functions, no latency, no backpressure.
// Widths up to MAX_BW; callers size-cast results back to their own token width.
package axi_dc_token_pkg;

  localparam int MAX_BW = 64;
  localparam int DEFAULT_BUFFER_WIDTH = 8;

  // Rotate left by one within the low w bits; bit w-1 wraps to bit 0.
  function automatic logic [MAX_BW-1:0] rotl(input logic [MAX_BW-1:0] v, input int w);
    logic [MAX_BW-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_BW; i++) begin
      if (i < w) r[i] = v[i-1];
    end
    for (int j = 0; j < MAX_BW; j++) begin
      if (j == w - 1) r[0] = v[j];
    end
    return r;
  endfunction

  function automatic logic [MAX_BW-1:0] onehot_rst();
    return MAX_BW'(1);
  endfunction

endpackage

// File: rtl/axi_dc_token_sync.sv
// Multi-flop synchronizer for the remote one-hot read pointer.
// Latency STAGES clk_i edges; no backpressure (free-running sampler).
// Resets to the one-hot "entry 0" value so it matches the writer's reset token.
module axi_dc_token_sync
  import axi_dc_token_pkg::*;
#(
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
  parameter int STAGES       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [BUFFER_WIDTH-1:0] pointer,
  output logic [BUFFER_WIDTH-1:0] pointer_sync
);

  localparam logic [BUFFER_WIDTH-1:0] RST_VAL = BUFFER_WIDTH'(onehot_rst());

  logic [BUFFER_WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < STAGES; s++) stage_q[s] <= RST_VAL;
    end else begin
      stage_q[0] <= pointer;
      for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign pointer_sync = stage_q[STAGES-1];

endmodule

// File: rtl/axi_dc_token_tx.sv
// Write half of a token-ring CDC channel; macro AXI_DC_TOKEN_TX_SYNC3_EN selects a 3-flop pointer sync.
// Token advances on the accepting edge; pointer-to-ready latency 2 edges (3 with the macro).
// ready_o drops when one free slot remains; stalled beats are simply not taken.
module axi_dc_token_tx
  import axi_dc_token_pkg::*;
#(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic                    ready_o,
  output logic [BUFFER_WIDTH-1:0] writetoken_o,
  output logic [DATA_WIDTH-1:0]   data_async_o,
  input  logic [BUFFER_WIDTH-1:0] readpointer_i
);

`ifdef AXI_DC_TOKEN_TX_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  localparam logic [BUFFER_WIDTH-1:0] WT_RST = BUFFER_WIDTH'(onehot_rst());

  logic [BUFFER_WIDTH-1:0] wt;
  logic [BUFFER_WIDTH-1:0] wt_next;
  logic [BUFFER_WIDTH-1:0] rp_sync;
  logic [DATA_WIDTH-1:0]   buffer [BUFFER_WIDTH];
  logic                    xfer;

  axi_dc_token_sync #(
    .BUFFER_WIDTH (BUFFER_WIDTH),
    .STAGES       (SYNC_STAGES)
  ) u_rp_sync (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .pointer      (readpointer_i),
    .pointer_sync (rp_sync)
  );

  assign wt_next = BUFFER_WIDTH'(rotl(MAX_BW'(wt), BUFFER_WIDTH));

  // Full when advancing would land on the reader's slot; keeps one entry empty.
  assign ready_o      = (wt_next != rp_sync);
  assign xfer         = valid_i && ready_o;
  assign writetoken_o = wt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wt <= WT_RST;
    end else if (xfer) begin
      wt <= wt_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_WIDTH; i++) buffer[i] <= '0;
    end else begin
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        if (xfer && wt[i]) buffer[i] <= data_i;
      end
    end
  end

  // Unregistered AND-OR read mux; the reader only samples entries it knows are settled.
  always_comb begin
    data_async_o = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      data_async_o = data_async_o | (buffer[i] & {DATA_WIDTH{readpointer_i[i]}});
    end
  end

endmodule

// File: tb/tb_axi_dc_token_tx.sv
// Scoreboard bench for axi_dc_token_tx: accepted beats queue up, reader model pops and compares.
module tb_axi_dc_token_tx;

`ifdef AXI_DC_TOKEN_TX_SYNC3_EN
  localparam int SYNC_N = 3;
`else
  localparam int SYNC_N = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        valid;
  logic [63:0] data;
  logic        ready;
  logic [7:0]  wtok;
  logic [63:0] dout;
  logic [7:0]  rp;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mwt;
  logic [7:0]  ms [SYNC_N];
  logic [63:0] sb [$];

  axi_dc_token_tx #(.DATA_WIDTH(64), .BUFFER_WIDTH(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .valid_i       (valid),
    .data_i        (data),
    .ready_o       (ready),
    .writetoken_o  (wtok),
    .data_async_o  (dout),
    .readpointer_i (rp)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rot(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic m_ready();
    return rot(mwt) != ms[SYNC_N-1];
  endfunction

  // Called at a falling edge with inputs set; returns at the next falling edge.
  task automatic cycle(output bit acc);
    chk("ready", {63'd0, ready}, {63'd0, m_ready()});
    chk("wtok", {56'd0, wtok}, {56'd0, mwt});
    chk("onehot", {63'd0, $onehot(wtok)}, 64'd1);
    acc = valid && m_ready();
    if (acc) sb.push_back(data);
    @(posedge clk);
    if (acc) mwt = rot(mwt);
    for (int s = SYNC_N - 1; s > 0; s--) ms[s] = ms[s-1];
    ms[0] = rp;
    @(negedge clk);
  endtask

  task automatic pop();
    logic [63:0] e;
    e = sb.pop_front();
    chk("rdata", dout, e);
    rp = rot(rp);
  endtask

  task automatic model_reset();
    mwt = 8'h01;
    for (int s = 0; s < SYNC_N; s++) ms[s] = 8'h01;
    sb.delete();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    chk("rst_wtok", {56'd0, wtok}, 64'h01);
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_dout", dout, 64'd0);
    rp    = 8'h01;
    valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    bit acc;
    int nacc;
    int lat;
    int sent;
    int rcv;
    int lag;

    rst_ni = 1'b0;
    valid  = 1'b0;
    data   = '0;
    rp     = 8'h01;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_wtok", {56'd0, wtok}, 64'h01);
    chk("init_ready", {63'd0, ready}, 64'd1);
    chk("init_dout", dout, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk);

    // fill to full with the reader parked on entry 0
    valid = 1'b1;
    data  = 64'hA0;
    nacc  = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(acc);
      if (acc) begin
        nacc++;
        data = 64'hA0 + 64'(nacc);
      end
    end
    chk("fill_cnt", 64'(nacc), 64'd7);
    chk("fill_wtok", {56'd0, wtok}, 64'h80);
    chk("fill_ready", {63'd0, ready}, 64'd0);

    // one pop reopens the channel after the synchronizer delay
    valid = 1'b0;
    pop();
    lat = 0;
    while (!ready && lat < 10) begin
      cycle(acc);
      lat++;
    end
    chk("reopen_lat", 64'(lat), 64'(SYNC_N));
    valid = 1'b1;
    cycle(acc);
    valid = 1'b0;
    chk("wrap_wtok", {56'd0, wtok}, 64'h01);

    // stalled beat at full must not disturb the token
    valid = 1'b1;
    data  = 64'hFF;
    for (int k = 0; k < 5; k++) begin
      cycle(acc);
      chk("full_wtok", {56'd0, wtok}, 64'h01);
    end
    pop();
    lat = 0;
    while (!ready && lat < 10) begin
      cycle(acc);
      lat++;
    end
    chk("full_lat", 64'(lat), 64'(SYNC_N));
    cycle(acc);
    chk("ff_wtok", {56'd0, wtok}, 64'h02);
    valid = 1'b0;
    while (sb.size() > 0) begin
      pop();
      cycle(acc);
    end

    // data path through the read mux
    do_reset();
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      data  = 64'h11 * 64'(k + 1);
      cycle(acc);
    end
    valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pop();
      cycle(acc);
    end

    // reset in the middle of a fill
    for (int k = 0; k < 3; k++) begin
      valid = 1'b1;
      data  = 64'h44 + 64'h11 * 64'(k);
      cycle(acc);
    end
    valid = 1'b0;
    chk("pre_rst_dout", dout, 64'h44);
    do_reset();

    // random reader lag, 100 beats
    sent  = 0;
    rcv   = 0;
    lag   = $urandom_range(0, 4);
    valid = 1'b0;
    for (int c = 0; c < 3000 && rcv < 100; c++) begin
      if (sb.size() > 0) begin
        if (lag == 0) begin
          pop();
          rcv++;
          lag = $urandom_range(0, 4);
        end else begin
          lag--;
        end
      end
      if (!valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        valid = 1'b1;
        data  = 64'h1000 + 64'(sent);
      end
      cycle(acc);
      if (acc) begin
        sent++;
        valid = 1'b0;
      end
    end
    chk("rand_rcv", 64'(rcv), 64'd100);
    chk("rand_sent", 64'(sent), 64'd100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
